// File: rtl/multibyte_add_pkg.sv
// Shared types and constants for the multi-byte add/subtract sequencer.
package multibyte_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int byte_slice(input int idx);
    return idx * BYTE_W;
  endfunction

endpackage

// File: rtl/multibyte_add_seq_byte_adder.sv
// Combinational 8-bit adder with carry-in/carry-out; time-shared by the sequencer.
module byte_adder
  import multibyte_add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [BYTE_W:0] full_d;

  assign full_d    = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  assign {cout, s} = full_d;

endmodule

// File: rtl/multibyte_add_seq.sv
// Adds/subtracts NBYTES*8-bit operands one byte per cycle, LSB first, through one shared byte adder.
// Defining MULTIBYTE_ADD_OVF_EN adds a registered signed-overflow output ovf.
module multibyte_add_seq
  import multibyte_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [NBYTES*BYTE_W-1:0] a,
  input  logic [NBYTES*BYTE_W-1:0] b,
  input  logic                     cin,
  input  logic                     op_sub,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NBYTES*BYTE_W-1:0] sum,
  output logic                     cout,
  output logic                     busy
`ifdef MULTIBYTE_ADD_OVF_EN
  ,output logic                    ovf
`endif
);

  localparam int W    = NBYTES * BYTE_W;
  localparam int IDXW = $clog2(NBYTES) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic              carry_q;
  logic [W-1:0]      sum_q;
  logic              cout_q;
  logic              res_valid_q;
  logic              busy_q;

  logic [BYTE_W-1:0] a_byte_d;
  logic [BYTE_W-1:0] b_byte_d;
  logic [BYTE_W-1:0] byte_sum_d;
  logic              byte_cout_d;

  assign a_byte_d = a_q[byte_slice(int'(idx_q)) +: BYTE_W];
  assign b_byte_d = b_q[byte_slice(int'(idx_q)) +: BYTE_W];

  byte_adder u_byte_adder (
    .a    (a_byte_d),
    .b    (b_byte_d),
    .cin  (carry_q),
    .s    (byte_sum_d),
    .cout (byte_cout_d)
  );

`ifdef MULTIBYTE_ADD_OVF_EN
  logic ovf_q;
  logic ovf_d;
  // Carry into the MSB is recovered from the MSB sum bit of the last slice.
  assign ovf_d = (a_byte_d[BYTE_W-1] ^ b_byte_d[BYTE_W-1] ^ byte_sum_d[BYTE_W-1]) ^ byte_cout_d;
  assign ovf   = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULTIBYTE_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= a;
            // Subtract is A + ~B + 1, so B is inverted once at capture.
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub | cin;
            idx_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[byte_slice(int'(idx_q)) +: BYTE_W] <= byte_sum_d;
          carry_q <= byte_cout_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q      <= byte_cout_d;
`ifdef MULTIBYTE_ADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = res_valid_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed scoreboard bench for multibyte_add_seq (NBYTES=4); ovf checked when MULTIBYTE_ADD_OVF_EN is defined.
module tb_multibyte_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = NBYTES * 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef MULTIBYTE_ADD_OVF_EN
  logic         ovf;
`endif

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .op_sub      (op_sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
`ifdef MULTIBYTE_ADD_OVF_EN
    ,.ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: a result is consumed at the edge after a negedge that shows valid & ready.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got sum=%0h with empty scoreboard", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, "_sum"}, 64'(sum), 64'(e.s));
        chk({e.nm, "_cout"}, 64'(cout), 64'(e.c));
`ifdef MULTIBYTE_ADD_OVF_EN
        chk({e.nm, "_ovf"}, 64'(ovf), 64'(e.o));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one operation in; returns edges from accept (counted as 1) to res_valid.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                       input logic sub, input bit junk, output int edges);
    int n;
    n = 0;
    while (!start_ready && n < 50) begin
      tick();
      n++;
    end
    if (!start_ready) begin
      total++;
      bad++;
      $display("FAIL start_ready_timeout: got 0 required 1");
    end
    a = ai; b = bi; cin = ci; op_sub = sub; start_valid = 1'b1;
    tick();
    // Operands may change freely after accept; optionally keep start_valid high with junk.
    a = $urandom; b = $urandom; cin = 1'($urandom); op_sub = 1'($urandom);
    start_valid = junk;
    edges = 1;
    while (!res_valid && edges < 50) begin
      tick();
      edges++;
    end
    start_valid = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic sub, input logic [W-1:0] es,
                        input logic ec, input logic eo, input bit junk);
    int edges;
    exp_q.push_back('{nm: nm, s: es, c: ec, o: eo});
    issue(ai, bi, ci, sub, junk, edges);
    chk({nm, "_latency"}, 64'(edges), 64'(NBYTES + 1));
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d pending required 0", nm, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    int edges;

    // Reset values while reset is held and just after release.
    #2;
    chk("rst_sum", 64'(sum), 64'h0);
    chk("rst_cout", 64'(cout), 64'h0);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_start_ready", 64'(start_ready), 64'h1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_start_ready", 64'(start_ready), 64'h1);

    run_op("carry_byte", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
    run_op("ripple",     32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op("cin_add",    32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op("sub_ovf",    32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_zero",   32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);

    // Backpressure: result must hold while res_ready is low.
    res_ready = 1'b0;
    exp_q.push_back('{nm: "backpressure", s: 32'h23456789, c: 1'b0, o: 1'b0});
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, edges);
    chk("bp_latency", 64'(edges), 64'(NBYTES + 1));
    for (int i = 0; i < 3; i++) begin
      chk("bp_res_valid", 64'(res_valid), 64'h1);
      chk("bp_sum", 64'(sum), 64'h23456789);
      chk("bp_start_ready", 64'(start_ready), 64'h0);
      chk("bp_busy", 64'(busy), 64'h1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("bp_release_start_ready", 64'(start_ready), 64'h1);
    chk("bp_release_res_valid", 64'(res_valid), 64'h0);
    chk("bp_release_busy", 64'(busy), 64'h0);
    chk("bp_scoreboard_empty", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    tick();

    // Reset during the second RUN cycle discards the operation.
    a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b0; op_sub = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrun_sum", 64'(sum), 64'h0);
    chk("midrun_res_valid", 64'(res_valid), 64'h0);
    chk("midrun_busy", 64'(busy), 64'h0);
    chk("midrun_start_ready", 64'(start_ready), 64'h1);
    tick();
    rst_n = 1'b1;
    repeat (NBYTES + 3) begin
      tick();
      chk("midrun_no_result", 64'(res_valid), 64'h0);
    end
    run_op("after_reset", 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
